// File: rtl/part_product_gen.sv
// Partial-product array front stage for the Dadda multiplier: AND array of a x b, registered once.
// Define PP_SIGNED_EN to build the Baugh-Wooley two's-complement array instead of the unsigned one.
module part_product_gen #(
  parameter int A_W = 8,
  parameter int B_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 in_valid,
  output logic [B_W*A_W-1:0]   pp,
  output logic                 out_valid
);

  logic [B_W*A_W-1:0] pp_d, pp_q;
  logic               out_valid_d, out_valid_q;

  function automatic logic [B_W*A_W-1:0] pp_array(input logic [A_W-1:0] a_v,
                                                   input logic [B_W-1:0] b_v);
    logic [B_W*A_W-1:0] arr;
    logic [A_W-1:0]     row;
    arr = '0;
    for (int i = 0; i < B_W; i++) begin
      row = a_v & {A_W{b_v[i]}};
`ifdef PP_SIGNED_EN
      // Sign row/column bits are inverted; the corner bit is flipped twice, so it stays plain.
      if (i == B_W-1) row = row ^ {1'b0, {(A_W-1){1'b1}}};
      else            row = row ^ {1'b1, {(A_W-1){1'b0}}};
`endif
      arr[i*A_W +: A_W] = row;
    end
    return arr;
  endfunction

  always_comb begin
    pp_d        = pp_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      pp_d        = pp_array(a, b);
      out_valid_d = 1'b1;
    end
  end

  // Stage boundary: operands -> registered array
  always_ff @(posedge clk) begin
    if (rst) begin
      pp_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pp_q        <= pp_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pp        = pp_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_part_product_gen.sv
// Directed + random bench for part_product_gen with a queue scoreboard of expected arrays.
module tb_part_product_gen;

  localparam int A_W = 8;
  localparam int B_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [A_W-1:0]      a;
  logic [B_W-1:0]      b;
  logic                in_valid;
  logic [B_W*A_W-1:0]  pp;
  logic                out_valid;

  int compared   = 0;
  int mismatched = 0;

  logic [B_W*A_W-1:0] sb_q[$];
  logic [B_W*A_W-1:0] exp_pp;
  logic               exp_v;

  part_product_gen #(.A_W(A_W), .B_W(B_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .pp        (pp),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [B_W*A_W-1:0] model(input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
    logic [B_W*A_W-1:0] m;
    logic bitv;
    m = '0;
    for (int i = 0; i < B_W; i++)
      for (int j = 0; j < A_W; j++) begin
        bitv = av[j] & bv[i];
`ifdef PP_SIGNED_EN
        if ((i == B_W-1) != (j == A_W-1)) bitv = ~bitv;
`endif
        m[i*A_W + j] = bitv;
      end
    return m;
  endfunction

  task automatic check(input string tag);
    compared++;
    assert (out_valid === exp_v) else begin
      mismatched++;
      $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_v);
    end
    compared++;
    assert (pp === exp_pp) else begin
      mismatched++;
      $error("FAIL %s pp observed=%h expected=%h", tag, pp, exp_pp);
    end
  endtask

  // Drives one cycle (with a mid-cycle glitch on the operands), then checks the DUT one step later.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [A_W-1:0] av, input logic [B_W-1:0] bv);
    rst = r; in_valid = v; a = ~av; b = ~bv;
    #2;
    a = av; b = bv;
    if (r) sb_q.delete();
    else if (v) sb_q.push_back(model(av, bv));
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = 1'b0; exp_pp = '0;
    end else if (v) begin
      exp_v = 1'b1;
      if (sb_q.size() == 0) begin
        mismatched++;
        $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, pp);
      end else exp_pp = sb_q.pop_front();
    end else begin
      exp_v = 1'b0;
    end
    a = ~av; b = ~bv;
    check(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    exp_pp = '0; exp_v = 1'b0;
    @(negedge clk);

    step("reset0", 1'b1, 1'b1, 8'hFF, 8'hFF);
    step("reset1", 1'b1, 1'b1, 8'hFF, 8'hFF);
    step("zero",   1'b0, 1'b1, 8'h00, 8'h00);
    step("ff_aa",  1'b0, 1'b1, 8'hFF, 8'hAA);
    step("ff_ff",  1'b0, 1'b1, 8'hFF, 8'hFF);
    step("hold",   1'b0, 1'b0, 8'h12, 8'h34);
    step("hold2",  1'b0, 1'b0, 8'h00, 8'hFF);
    step("b2b_0",  1'b0, 1'b1, 8'h5A, 8'h01);
    step("b2b_1",  1'b0, 1'b1, 8'hC3, 8'h80);
    step("a_zero", 1'b0, 1'b1, 8'h00, 8'hFF);
    step("b_zero", 1'b0, 1'b1, 8'hFF, 8'h00);
    step("mixed",  1'b0, 1'b1, 8'h81, 8'h3C);

    for (int k = 0; k < 20; k++)
      step("rand", 1'b0, ($urandom_range(0, 3) != 0),
           A_W'($urandom_range(0, 255)), B_W'($urandom_range(0, 255)));

    step("rst_prio", 1'b1, 1'b1, 8'hA5, 8'h5A);
    step("post_rst", 1'b0, 1'b1, 8'h7E, 8'hE7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
